// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, imem handshake, stall/branch handling.
// Optional retired-fetch counter output enabled by defining FETCH_STATS_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        ref_clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_plus4,
  output logic        clren
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        clren_q, clren_d;

  always_ff @(posedge ref_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (branch_taken) begin
      state_d = REQ;
    end else begin
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     if (imem_ready && stall) state_d = HOLD;
        HOLD:    if (!stall) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = (state_q == REQ);
    imem_addr = pc_q;
    inst_out  = inst_q;
    pc_plus4  = pcp4_q;
    clren     = clren_q;
  end

  // A stalled fetch captures its word and return address now; the PC only
  // moves on release, so the HOLD exit presents exactly what was captured.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pcp4_d  = pcp4_q;
    clren_d = 1'b0;
    if (branch_taken) begin
      pc_d = {branch_target[31:2], 2'b00};
    end else begin
      case (state_q)
        REQ: begin
          if (imem_ready) begin
            inst_d = imem_rdata;
            pcp4_d = pc_q + STEP;
            if (!stall) begin
              pc_d    = pc_q + STEP;
              clren_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_d    = pc_q + STEP;
            clren_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pcp4_q  <= 32'h0;
      clren_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pcp4_q  <= pcp4_d;
      clren_q <= clren_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] count_q;

  always_ff @(posedge ref_clk) begin
    if (reset)        count_q <= 32'h0;
    else if (clren_q) count_q <= count_q + 32'd1;
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed test of fetch_unit: sequential fetch, wait states, stall, branch,
// PC wrap and reset mid-request, plus the fetch counter when enabled.
module tb_fetch_unit;

  logic        ref_clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_plus4;
  logic        clren;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .ref_clk      (ref_clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .inst_out     (inst_out),
    .pc_plus4     (pc_plus4),
    .clren        (clren)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count  (fetch_count)
`endif
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // req / addr / clren / inst / pc_plus4 in one call, one line per transaction
  task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic cl, input logic [31:0] inst, input logic [31:0] pcp4);
    $display("%s: req=%0b addr=%h clren=%0b inst=%h pc_plus4=%h",
             tag, imem_req, imem_addr, clren, inst_out, pc_plus4);
    check({tag, ".req"},   {31'h0, imem_req}, {31'h0, req});
    check({tag, ".addr"},  imem_addr, addr);
    check({tag, ".clren"}, {31'h0, clren}, {31'h0, cl});
    check({tag, ".inst"},  inst_out, inst);
    check({tag, ".pcp4"},  pc_plus4, pcp4);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ready = 1'b1; imem_rdata = 32'h9999_9999;
    step(); step();
    check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // sequential fetch, single-cycle memory
    reset = 1'b0; imem_rdata = 32'h2008_0005;
    step();
    check_all("idle_to_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    check_all("fetch0", 1'b1, 32'h4, 1'b1, 32'h2008_0005, 32'h4);
    imem_rdata = 32'hAAAA_0004;
    step();
    check_all("fetch4", 1'b1, 32'h8, 1'b1, 32'hAAAA_0004, 32'h8);

    // three wait states at PC=8
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    step(); check_all("wait1", 1'b1, 32'h8, 1'b0, 32'hAAAA_0004, 32'h8);
    step(); check_all("wait2", 1'b1, 32'h8, 1'b0, 32'hAAAA_0004, 32'h8);
    step(); check_all("wait3", 1'b1, 32'h8, 1'b0, 32'hAAAA_0004, 32'h8);
    imem_ready = 1'b1; imem_rdata = 32'hBBBB_0008;
    step();
    check_all("fetch8", 1'b1, 32'hC, 1'b1, 32'hBBBB_0008, 32'hC);
    imem_rdata = 32'hCCCC_000C;
    step();
    check_all("fetchC", 1'b1, 32'h10, 1'b1, 32'hCCCC_000C, 32'h10);

    // stall for two cycles while fetching PC=16
    stall = 1'b1; imem_rdata = 32'hDDDD_0010;
    step();
    check_all("hold1", 1'b0, 32'h10, 1'b0, 32'hDDDD_0010, 32'h14);
    imem_rdata = 32'h5555_5555;
    step();
    check_all("hold2", 1'b0, 32'h10, 1'b0, 32'hDDDD_0010, 32'h14);
    stall = 1'b0;
    step();
    check_all("release", 1'b1, 32'h14, 1'b1, 32'hDDDD_0010, 32'h14);

    // branch coincident with ready: data discarded, low bits cleared
    branch_taken = 1'b1; branch_target = 32'h0000_0043; imem_rdata = 32'hEEEE_0014;
    step();
    check_all("branch43", 1'b1, 32'h40, 1'b0, 32'hDDDD_0010, 32'h14);
    branch_taken = 1'b0; imem_rdata = 32'h1234_5678;
    step();
    check_all("fetch40", 1'b1, 32'h44, 1'b1, 32'h1234_5678, 32'h44);

    // branch to top of address space, then wrap
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    check_all("branch_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h1234_5678, 32'h44);
    branch_taken = 1'b0; imem_rdata = 32'hCAFE_F00D;
    step();
    check_all("wrap", 1'b1, 32'h0, 1'b1, 32'hCAFE_F00D, 32'h0);

    // branch has priority over stall in HOLD
    stall = 1'b1; imem_rdata = 32'h7777_0000;
    step();
    check_all("hold_b", 1'b0, 32'h0, 1'b0, 32'h7777_0000, 32'h4);
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    step();
    check_all("hold_branch", 1'b1, 32'h100, 1'b0, 32'h7777_0000, 32'h4);
    branch_taken = 1'b0; stall = 1'b0;

    // reset mid-request abandons it
    imem_ready = 1'b0;
    step();
    check_all("pending", 1'b1, 32'h100, 1'b0, 32'h7777_0000, 32'h4);
    reset = 1'b1;
    step();
    check_all("reset_mid", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

`ifdef FETCH_STATS_EN
    check("count_reset", fetch_count, 32'd0);
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_0013;
    step(); step(); step(); step();
    stall = 1'b1;
    step(); step();
    stall = 1'b0;
    step(); step();
    imem_ready = 1'b0;
    step(); step();
    check("count5", fetch_count, 32'd5);
    reset = 1'b1;
    step();
    check("count_clear", fetch_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
